// File: rtl/arb_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux_pkg
// Brief    : Shared constants and index-width helper for the arb_mux block.
// Revision : 1.0
// ============================================================================
package arb_mux_pkg;

    localparam int MIN_CH = 2;
    localparam int MAX_CH = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux_if
// Brief    : Channel-side and output-side handshake bundle for arb_mux.
// Revision : 1.0
// ============================================================================
interface arb_mux_if
    import arb_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4
);
    localparam int IDX_W = clog2(NUM_CH);

    logic [NUM_CH*DATA_WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH-1:0]            in_ready;
    logic                         force_en;
    logic [IDX_W-1:0]             force_sel;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [IDX_W-1:0]             out_ch;
    logic                         out_valid;
    logic                         out_ready;

    modport slave (
        input  in_data, in_valid, force_en, force_sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

    modport master (
        output in_data, in_valid, force_en, force_sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

endinterface
`default_nettype wire

// File: rtl/arb_mux_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational first-requester search starting at i_start, wrapping.
// Revision : 1.0
// ============================================================================
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_start,
    output logic [NUM_CH-1:0] o_grant,
    output logic [IDX_W-1:0]  o_idx
);

    // Scan from the farthest position inward so the nearest requester is the last write.
    always_comb begin : p_search
        int j;
        o_grant = '0;
        o_idx   = '0;
        j       = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            j = int'(i_start) + k;
            if (j >= NUM_CH) begin
                j = j - NUM_CH;
            end
            if (i_req[j]) begin
                o_grant    = '0;
                o_grant[j] = 1'b1;
                o_idx      = IDX_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux
// Brief    : NUM_CH-way registered mux with valid/ready handshake and arbitration.
//            RR_ARB_EN defined: round-robin; undefined: fixed lowest-index priority.
// Revision : 1.0
// ============================================================================
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4
) (
    input  logic     CLK,
    input  logic     RST,
    arb_mux_if.slave bus
);

    localparam int                IDX_W     = clog2(NUM_CH);
    localparam logic [IDX_W:0]    c_NUM_CH  = (IDX_W+1)'(NUM_CH);
    localparam logic [IDX_W-1:0]  c_LAST_CH = IDX_W'(NUM_CH - 1);

    logic [NUM_CH-1:0]     w_force_req;
    logic [NUM_CH-1:0]     w_req;
    logic [NUM_CH-1:0]     w_grant;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      w_start;
    logic                  w_in_range;
    logic                  w_free;
    logic                  w_xfer;

    logic [DATA_WIDTH-1:0] r_data;
    logic [IDX_W-1:0]      r_ch;
    logic                  r_valid;

    // An out-of-range forced index yields no request at all.
    assign w_in_range  = ({1'b0, bus.force_sel} < c_NUM_CH);
    assign w_force_req = w_in_range ? (NUM_CH'(1) << bus.force_sel) : '0;
    assign w_req       = bus.force_en ? (w_force_req & bus.in_valid) : bus.in_valid;

`ifdef RR_ARB_EN
    logic [IDX_W-1:0] r_last_ptr;

    assign w_start = (r_last_ptr == c_LAST_CH) ? '0 : r_last_ptr + 1'b1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_last_ptr <= c_LAST_CH;
        end else if (w_xfer) begin
            r_last_ptr <= w_idx;
        end
    end
`else
    assign w_start = '0;
`endif

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .i_req   (w_req),
        .i_start (w_start),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_free       = !r_valid || bus.out_ready;
    assign bus.in_ready = (w_free && RST) ? w_grant : '0;
    assign w_xfer       = |(bus.in_valid & bus.in_ready);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data  <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
        end else if (w_free) begin
            if (w_xfer) begin
                r_data  <= bus.in_data[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
                r_ch    <= w_idx;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_data;
    assign bus.out_ch    = r_ch;
    assign bus.out_valid = r_valid;

endmodule
`default_nettype wire
